io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
//  Device-side responder for the CPU's memory-mapped I/O bus, driven by the MEM stage. It holds
//  the three output-port registers and synchronises and debounces the two input ports. It also
//  keeps sticky change flags and returns registered read data to the MEM stage.
// PARAMETERS
//  DATA_W           32  width of port registers and bus data
//  DEBOUNCE_CYCLES  4   consecutive stable synchronised samples required to commit an input (>=1)
//  OUT_RESET        0   reset value of out_port0..2
// PORTS
//  clock      in   1       system clock; all state updates on rising edge
//  reset      in   1       asynchronous, active-high reset
//  io_addr    in   8       byte address within I/O window; bits[1:0] ignored
//  io_wdata   in   DATA_W  write data (CPU store operand)
//  io_we      in   1       write strobe, one cycle per store
//  io_re      in   1       read strobe, one cycle per load
//  io_rdata   out  DATA_W  registered read data
//  io_rvalid  out  1       pulses 1 cycle after io_re
//  io_err     out  1       pulses 1 cycle after an access to an unmapped or read-only location
//  in_port0   in   DATA_W  asynchronous input word (switches)
//  in_port1   in   DATA_W  asynchronous input word (switches)
//  out_port0  out  DATA_W  output register OUT0 (display)
//  out_port1  out  DATA_W  output register OUT1
//  out_port2  out  DATA_W  output register OUT2
//  irq        out  1       |(STATUS[1:0] & MASK[1:0]), registered
// BEHAVIOUR
//  Register map (word offsets):
//   0x80 OUT0 RW | 0x84 OUT1 RW | 0x88 OUT2 RW
//   0xC0 IN0 RO  | 0xC4 IN1 RO
//   0xC8 STATUS: bit0 = IN0 changed, bit1 = IN1 changed; sticky, write-1-to-clear
//   0xCC MASK RW: bits[1:0] used, other bits read as 0
//  Reset (asynchronous):
//   out_port* = OUT_RESET; io_rdata = 0; io_rvalid = io_err = irq = 0; STATUS = MASK = 0
//   sync FFs, candidate, and debounced IN regs = 0; debounce counters = 0
//  Writes: the register updates on the io_we edge and is visible on the out_port one cycle later.
//   Write to IN0/IN1 or to an unmapped address: no state change, io_err pulses next cycle.
//  Reads: io_re samples the register value before this edge's updates. io_rdata and io_rvalid
//   are valid on the next cycle. io_rdata holds its last value when io_rvalid=0.
//   Read of an unmapped address: io_rdata=0, io_rvalid=1, io_err=1.
//  io_we and io_re high together: the write is performed, the read returns the pre-write value,
//   and io_rvalid pulses.
//  Input path, one per port:
//   in_port -> 2-FF synchroniser -> s
//   Per-port FSM, states IDLE and COUNT:
//    IDLE:  if s != deb, load cand = s, cnt = 1, go to COUNT.
//    COUNT: if s != cand, reload cand = s and cnt = 1.
//           else if cnt == DEBOUNCE_CYCLES, commit deb = cand, set STATUS bit, go to IDLE.
//           else cnt++.
//           If s returns to deb before commit, return to IDLE with no flag.
//   With DEBOUNCE_CYCLES=1: commit happens the cycle after entering COUNT.
//   Latency from input change to IN register update = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
//   Counter width is clog2(DEBOUNCE_CYCLES+1); the counter never wraps because commit precedes
//   overflow.
//  STATUS set and W1C clear on the same edge: set wins, bit stays 1.
//  irq is a registered copy of the STATUS&MASK reduction, so it lags STATUS by one cycle.
//  reset mid-debounce: FSM returns to IDLE and the pending candidate is discarded.
// TESTING
//  1. Reset, then read OUT0/IN0/STATUS/MASK -> all read 0; out_port0..2 = 0; irq = 0.
//  2. Write 0x0000_1234 to 0x84 -> out_port1 = 0x1234 next cycle. A read of 0x84 in the same
//     cycle returns the old value 0; a read one cycle later returns 0x1234.
//  3. Set in_port0 = 0xA5 and hold it, DEBOUNCE_CYCLES=4 -> IN0 = 0xA5 exactly 7 cycles later.
//     STATUS = 0x1; with MASK = 0x1, irq = 1 one cycle after that.
//  4. Glitch: in_port0 = 0xFF for 2 cycles, then back to 0 -> IN0 stays 0 and STATUS stays 0.
//  5. Write 0x1 to STATUS on the same edge that IN0 commits a new value -> STATUS bit0 remains 1.
//     A later W1C of 0x1 clears it, and irq drops the following cycle.
//  6. Write to 0xC0 and read 0x90 -> io_err pulses each time, IN0 is unchanged, read data = 0.
//     Assert reset during COUNT -> IN0 = 0 and no flag afterwards.

Source files
------------

// File: rtl/io_port_responder.sv
// ---------------------------------------------------------------------------
// io_port_responder
//   Device-side responder on the CPU's memory-mapped I/O bus, driven by the
//   MEM stage. It holds three output-port registers and brings two
//   asynchronous input words in through a synchroniser and a debouncer. It
//   also keeps sticky change flags with an interrupt mask, and returns
//   registered read data.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   io_addr               byte address inside the I/O window (bits[1:0] unused)
//   io_wdata, io_we       store data and one-cycle write strobe
//   io_re                 one-cycle read strobe
//   io_rdata, io_rvalid   registered read data, valid one cycle after io_re
//   io_err                pulses one cycle after an unmapped/read-only access
//   in_port0, in_port1    asynchronous input words (switches)
//   out_port0..2          output registers OUT0..OUT2
//   irq                   registered |(STATUS & MASK)
//
// Register map (byte address)
//   0x80 OUT0 | 0x84 OUT1 | 0x88 OUT2 | 0xC0 IN0 (RO) | 0xC4 IN1 (RO)
//   0xC8 STATUS (sticky change flags, write-1-to-clear) | 0xCC MASK [1:0]
// ---------------------------------------------------------------------------
module io_port_responder #(
  parameter int unsigned        DATA_W          = 32,
  parameter int unsigned        DEBOUNCE_CYCLES = 4,
  parameter logic [DATA_W-1:0]  OUT_RESET       = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_we,
  input  logic              io_re,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_rvalid,
  output logic              io_err,
  input  logic [DATA_W-1:0] in_port0,
  input  logic [DATA_W-1:0] in_port1,
  output logic [DATA_W-1:0] out_port0,
  output logic [DATA_W-1:0] out_port1,
  output logic [DATA_W-1:0] out_port2,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  // Word offsets (byte address >> 2)
  localparam logic [5:0] A_OUT0   = 6'h20;
  localparam logic [5:0] A_OUT1   = 6'h21;
  localparam logic [5:0] A_OUT2   = 6'h22;
  localparam logic [5:0] A_IN0    = 6'h30;
  localparam logic [5:0] A_IN1    = 6'h31;
  localparam logic [5:0] A_STATUS = 6'h32;
  localparam logic [5:0] A_MASK   = 6'h33;

  typedef enum logic {IDLE, COUNT} debState_t;

  logic [5:0]        w_word;
  logic              w_unusedAddr;
  logic [DATA_W-1:0] w_inPort [2];

  logic [DATA_W-1:0] r_sync1 [2];
  logic [DATA_W-1:0] r_sync2 [2];
  logic [DATA_W-1:0] r_cand  [2];
  logic [DATA_W-1:0] r_deb   [2];
  logic [CNT_W-1:0]  r_cnt   [2];
  debState_t         r_state [2];

  logic [1:0]        w_commit;
  logic [1:0]        w_w1c;
  logic              w_mapped;
  logic              w_readOnly;
  logic [DATA_W-1:0] w_rdMux;

  logic [DATA_W-1:0] r_out0, r_out1, r_out2;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid, r_err, r_irq;
  logic [1:0]        r_status, r_mask;

  assign w_word       = io_addr[7:2];
  assign w_unusedAddr = &{1'b0, io_addr[1:0]};
  assign w_inPort[0]  = in_port0;
  assign w_inPort[1]  = in_port1;

  // Two-flop synchronisers for both input words
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        r_sync1[p] <= '0;
        r_sync2[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_sync1[p] <= w_inPort[p];
        r_sync2[p] <= r_sync1[p];
      end
    end
  end

  // A commit happens when a stable candidate has been seen DEBOUNCE_CYCLES
  // times in a row; STATUS needs to know on the same edge.
  always_comb begin
    w_commit = 2'b00;
    for (int p = 0; p < 2; p++) begin
      w_commit[p] = (r_state[p] == COUNT) && (r_sync2[p] != r_deb[p]) &&
                    (r_sync2[p] == r_cand[p]) && (r_cnt[p] == CNT_DONE);
    end
  end

  // Debounce FSM per port. Returning to the committed value abandons the
  // candidate; a different value restarts the count on the new candidate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= IDLE;
        r_cand[p]  <= '0;
        r_cnt[p]   <= '0;
        r_deb[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        case (r_state[p])
          IDLE: begin
            if (r_sync2[p] != r_deb[p]) begin
              r_cand[p]  <= r_sync2[p];
              r_cnt[p]   <= CNT_ONE;
              r_state[p] <= COUNT;
            end
          end
          COUNT: begin
            if (r_sync2[p] == r_deb[p]) begin
              r_state[p] <= IDLE;
            end else if (r_sync2[p] != r_cand[p]) begin
              r_cand[p] <= r_sync2[p];
              r_cnt[p]  <= CNT_ONE;
            end else if (r_cnt[p] == CNT_DONE) begin
              r_deb[p]   <= r_cand[p];
              r_state[p] <= IDLE;
            end else begin
              r_cnt[p] <= r_cnt[p] + CNT_ONE;
            end
          end
          default: r_state[p] <= IDLE;
        endcase
      end
    end
  end

  // Address decode and read mux; unmapped reads return zero
  always_comb begin
    w_mapped   = 1'b1;
    w_readOnly = 1'b0;
    w_rdMux    = '0;
    case (w_word)
      A_OUT0:   w_rdMux = r_out0;
      A_OUT1:   w_rdMux = r_out1;
      A_OUT2:   w_rdMux = r_out2;
      A_IN0: begin
        w_rdMux    = r_deb[0];
        w_readOnly = 1'b1;
      end
      A_IN1: begin
        w_rdMux    = r_deb[1];
        w_readOnly = 1'b1;
      end
      A_STATUS: w_rdMux = {{(DATA_W-2){1'b0}}, r_status};
      A_MASK:   w_rdMux = {{(DATA_W-2){1'b0}}, r_mask};
      default:  w_mapped = 1'b0;
    endcase
  end

  assign w_w1c = (io_we && (w_word == A_STATUS)) ? io_wdata[1:0] : 2'b00;

  // Bus side: register writes, registered read response, error pulse,
  // sticky status (a same-edge set beats a clear) and the lagging irq.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out0   <= OUT_RESET;
      r_out1   <= OUT_RESET;
      r_out2   <= OUT_RESET;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_status <= 2'b00;
      r_mask   <= 2'b00;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= io_re;
      r_err    <= (io_re && !w_mapped) || (io_we && (!w_mapped || w_readOnly));
      if (io_re) begin
        r_rdata <= w_rdMux;
      end
      if (io_we) begin
        case (w_word)
          A_OUT0:  r_out0 <= io_wdata;
          A_OUT1:  r_out1 <= io_wdata;
          A_OUT2:  r_out2 <= io_wdata;
          A_MASK:  r_mask <= io_wdata[1:0];
          default: ;
        endcase
      end
      r_status <= (r_status & ~w_w1c) | w_commit;
      r_irq    <= |(r_status & r_mask);
    end
  end

  assign io_rdata  = r_rdata;
  assign io_rvalid = r_rvalid;
  assign io_err    = r_err | w_unusedAddr;
  assign out_port0 = r_out0;
  assign out_port1 = r_out1;
  assign out_port2 = r_out2;
  assign irq       = r_irq;

endmodule

// File: tb/tb_io_port_responder.sv
// ---------------------------------------------------------------------------
// tb_io_port_responder
//   Directed bench for io_port_responder (DATA_W=32, DEBOUNCE_CYCLES=4).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge that follows each rising edge.
// ---------------------------------------------------------------------------
module tb_io_port_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ioAddr = '0;
  logic [31:0] ioWdata = '0;
  logic        ioWe = 1'b0;
  logic        ioRe = 1'b0;
  logic [31:0] ioRdata;
  logic        ioRvalid;
  logic        ioErr;
  logic [31:0] inPort0 = '0;
  logic [31:0] inPort1 = '0;
  logic [31:0] outPort0, outPort1, outPort2;
  logic        irq;

  int checkCount = 0;
  int passCount  = 0;

  io_port_responder #(
    .DATA_W(32),
    .DEBOUNCE_CYCLES(4),
    .OUT_RESET(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_addr(ioAddr),
    .io_wdata(ioWdata),
    .io_we(ioWe),
    .io_re(ioRe),
    .io_rdata(ioRdata),
    .io_rvalid(ioRvalid),
    .io_err(ioErr),
    .in_port0(inPort0),
    .in_port1(inPort1),
    .out_port0(outPort0),
    .out_port1(outPort1),
    .out_port2(outPort2),
    .irq(irq)
  );

  always #5 clock = ~clock;

  // Counts a comparison and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one bus cycle from a falling edge and returns at the next one
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] wdata,
                               input logic we, input logic re);
    ioAddr  = addr;
    ioWdata = wdata;
    ioWe    = we;
    ioRe    = re;
    @(negedge clock);
    ioWe = 1'b0;
    ioRe = 1'b0;
  endtask

  // Reads an address and checks data, valid and error together
  task automatic readCheck(input string tag, input logic [7:0] addr,
                           input logic [31:0] expData, input logic expErr);
    applyStimulus(addr, 32'h0, 1'b0, 1'b1);
    checkOutput({tag, " data"}, ioRdata, expData);
    checkOutput({tag, " rvalid"}, {31'b0, ioRvalid}, 32'h1);
    checkOutput({tag, " err"}, {31'b0, ioErr}, {31'b0, expErr});
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // --- reset state ---
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset out0", outPort0, 32'h0);
    checkOutput("reset out1", outPort1, 32'h0);
    checkOutput("reset out2", outPort2, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'h0);
    checkOutput("reset rvalid", {31'b0, ioRvalid}, 32'h0);
    readCheck("rst OUT0", 8'h80, 32'h0, 1'b0);
    readCheck("rst IN0", 8'hC0, 32'h0, 1'b0);
    readCheck("rst STATUS", 8'hC8, 32'h0, 1'b0);
    readCheck("rst MASK", 8'hCC, 32'h0, 1'b0);

    // --- writes, read-during-write returns old value ---
    applyStimulus(8'h84, 32'h0000_1234, 1'b1, 1'b1);
    checkOutput("rw OUT1 old data", ioRdata, 32'h0);
    checkOutput("rw OUT1 rvalid", {31'b0, ioRvalid}, 32'h1);
    checkOutput("rw out1 port", outPort1, 32'h0000_1234);
    readCheck("rd OUT1", 8'h84, 32'h0000_1234, 1'b0);
    applyStimulus(8'h00, 32'h0, 1'b0, 1'b0);
    checkOutput("rdata hold", ioRdata, 32'h0000_1234);
    checkOutput("rvalid idle", {31'b0, ioRvalid}, 32'h0);
    applyStimulus(8'h80, 32'hCAFE_0001, 1'b1, 1'b0);
    checkOutput("out0 port", outPort0, 32'hCAFE_0001);
    applyStimulus(8'h8B, 32'h8000_0002, 1'b1, 1'b0);
    checkOutput("out2 port low bits ignored", outPort2, 32'h8000_0002);
    applyStimulus(8'hCC, 32'hFFFF_FFFF, 1'b1, 1'b0);
    readCheck("MASK upper zero", 8'hCC, 32'h3, 1'b0);
    applyStimulus(8'hCC, 32'h1, 1'b1, 1'b0);

    // --- IN0 commit latency: continuous reads of IN0 ---
    // The read completing after edge k shows IN0 as it was after edge k-1.
    inPort0 = 32'hA5;
    ioAddr  = 8'hC0;
    ioRe    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      checkOutput($sformatf("IN0 latency edge %0d", k), ioRdata,
                  (k >= 8) ? 32'hA5 : 32'h0);
      checkOutput($sformatf("irq edge %0d", k), {31'b0, irq},
                  (k >= 8) ? 32'h1 : 32'h0);
    end
    ioRe = 1'b0;
    readCheck("STATUS after IN0", 8'hC8, 32'h1, 1'b0);

    // W1C clear: irq lags the cleared flag by one cycle
    applyStimulus(8'hC8, 32'h1, 1'b1, 1'b0);
    checkOutput("irq lag after clear", {31'b0, irq}, 32'h1);
    applyStimulus(8'h00, 32'h0, 1'b0, 1'b0);
    checkOutput("irq dropped", {31'b0, irq}, 32'h0);
    readCheck("STATUS cleared", 8'hC8, 32'h0, 1'b0);

    // --- glitches on both ports ---
    inPort0 = 32'hFF;
    inPort1 = 32'hFF;
    repeat (2) @(negedge clock);
    inPort0 = 32'hA5;
    inPort1 = 32'h0;
    repeat (12) @(negedge clock);
    readCheck("glitch IN0", 8'hC0, 32'hA5, 1'b0);
    readCheck("glitch IN1", 8'hC4, 32'h0, 1'b0);
    readCheck("glitch STATUS", 8'hC8, 32'h0, 1'b0);

    // --- IN1 commit, masked from irq ---
    inPort1 = 32'h5A5A;
    repeat (10) @(negedge clock);
    readCheck("IN1 commit", 8'hC4, 32'h5A5A, 1'b0);
    readCheck("STATUS IN1", 8'hC8, 32'h2, 1'b0);
    checkOutput("irq masked", {31'b0, irq}, 32'h0);
    applyStimulus(8'hC8, 32'h2, 1'b1, 1'b0);
    readCheck("STATUS IN1 cleared", 8'hC8, 32'h0, 1'b0);

    // --- set and clear on the same edge: set wins ---
    inPort0 = 32'h3C;
    repeat (6) @(negedge clock);
    applyStimulus(8'hC8, 32'h1, 1'b1, 1'b0);
    readCheck("STATUS set wins", 8'hC8, 32'h1, 1'b0);
    checkOutput("irq after set", {31'b0, irq}, 32'h1);
    readCheck("IN0 new", 8'hC0, 32'h3C, 1'b0);
    applyStimulus(8'hC8, 32'h1, 1'b1, 1'b0);
    checkOutput("irq lag second clear", {31'b0, irq}, 32'h1);
    applyStimulus(8'h00, 32'h0, 1'b0, 1'b0);
    checkOutput("irq dropped second", {31'b0, irq}, 32'h0);

    // --- illegal accesses ---
    applyStimulus(8'hC0, 32'hDEAD, 1'b1, 1'b0);
    checkOutput("wr IN0 err", {31'b0, ioErr}, 32'h1);
    applyStimulus(8'h00, 32'h0, 1'b0, 1'b0);
    checkOutput("err pulse ends", {31'b0, ioErr}, 32'h0);
    readCheck("IN0 after bad write", 8'hC0, 32'h3C, 1'b0);
    readCheck("rd unmapped", 8'h90, 32'h0, 1'b1);
    applyStimulus(8'h90, 32'h1111, 1'b1, 1'b0);
    checkOutput("wr unmapped err", {31'b0, ioErr}, 32'h1);
    checkOutput("out0 untouched", outPort0, 32'hCAFE_0001);

    // --- reset while a candidate is counting ---
    inPort0 = 32'h77;
    repeat (4) @(negedge clock);
    #2;
    reset   = 1'b1;
    inPort0 = 32'h0;
    inPort1 = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("post-reset out0", outPort0, 32'h0);
    checkOutput("post-reset irq", {31'b0, irq}, 32'h0);
    readCheck("post-reset IN0", 8'hC0, 32'h0, 1'b0);
    readCheck("post-reset STATUS", 8'hC8, 32'h0, 1'b0);
    readCheck("post-reset MASK", 8'hCC, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
